// File: rtl/sequence_detect.sv
// Moore detector for the serial code 01101110 (first bit received is the MSB).
// Overlapping matches are supported; o_done pulses for one cycle per match.
module sequence_detect (
    input  logic clk,
    input  logic rst,
    input  logic seed,
    output logic o_done
);

    typedef enum logic [3:0] {
        S0 = 4'd0,
        S1 = 4'd1,
        S2 = 4'd2,
        S3 = 4'd3,
        S4 = 4'd4,
        S5 = 4'd5,
        S6 = 4'd6,
        S7 = 4'd7,
        S8 = 4'd8
    } state_t;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S0;
        end else begin
            r_state <= w_next;
        end
    end

    // Failure edges fall back to the longest suffix that is still a pattern prefix.
    always_comb begin
        w_next = S0;
        case (r_state)
            S0:      w_next = seed ? S0 : S1;
            S1:      w_next = seed ? S2 : S1;
            S2:      w_next = seed ? S3 : S1;
            S3:      w_next = seed ? S0 : S4;
            S4:      w_next = seed ? S5 : S1;
            S5:      w_next = seed ? S6 : S1;
            S6:      w_next = seed ? S7 : S4;
            S7:      w_next = seed ? S0 : S8;
            S8:      w_next = seed ? S2 : S1;
            default: w_next = S0;
        endcase
    end

    always_comb begin
        o_done = (r_state == S8);
    end

endmodule

// File: tb/tb_sequence_detect.sv
// Directed bench for sequence_detect: stimulus pushes the expected o_done for
// each bit into a queue; a monitor pops one entry per sampled bit and compares.
module tb_sequence_detect;

    logic clk;
    logic rst;
    logic seed;
    logic o_done;

    int   checks   = 0;
    int   failures = 0;
    int   bitCount = 0;
    logic expQ[$];

    sequence_detect dut (
        .clk    (clk),
        .rst    (rst),
        .seed   (seed),
        .o_done (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: o_done=%b expected %b", name, act, exp);
        end
    endtask

    // Drives one bit, records its expected response, returns 1 time unit after the edge.
    task automatic applyStimulus(input logic b, input logic e);
        seed = b;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Feeds n bits MSB-first, then waits for the monitor to see the last one
    // without letting another rising edge through.
    task automatic runVec(input logic [63:0] bits, input logic [63:0] exps, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(bits[n-1-i], exps[n-1-i]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: pending=%0d expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic doReset();
        rst = 1'b0;
        #1;
        checkOutput("resetAsync", o_done, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("resetHold%0d", i), o_done, 1'b0);
            seed = ~seed;
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
    endtask

    // Monitor: every edge that has a queued expectation is checked mid-cycle.
    initial begin
        logic e;
        forever begin
            @(posedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                @(negedge clk);
                checkOutput($sformatf("bit%0d", bitCount), o_done, e);
                bitCount++;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst  = 1'b0;
        seed = 1'b0;
        @(posedge clk);
        #1;

        doReset();
        $display("[TB] single match");
        runVec(64'b01101110, 64'b00000001, 8);

        doReset();
        $display("[TB] overlapping matches");
        runVec(64'b011011101101110, 64'b000000010000001, 15);

        doReset();
        $display("[TB] near misses");
        runVec(64'b0110111101101101110, 64'b0000000000000000001, 19);

        doReset();
        $display("[TB] bit-held stimulus");
        runVec({8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00}, 64'd0, 64);

        doReset();
        $display("[TB] mid-match reset");
        runVec(64'b011011, 64'b000000, 6);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        runVec(64'b10, 64'b00, 2);
        runVec(64'b01101110, 64'b00000001, 8);

        doReset();
        $display("[TB] reset clears a live pulse");
        runVec(64'b0110111, 64'b0000000, 7);
        seed = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("asyncPre", o_done, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("asyncClear", o_done, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("asyncHold", o_done, 1'b0);
        rst = 1'b1;
        runVec(64'b01101110, 64'b00000001, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
